// File: rtl/pattern_pkg.sv
// Shared definitions for the lane test pattern generator and checker.
// Holds the default word encodings, the sequence length, the expected
// sequence in index order and the checker state type.
package pattern_pkg;

    localparam int unsigned IO_SIZE_C = 3;
    localparam int unsigned SEQ_LEN_C = 12;

    typedef logic [IO_SIZE_C-1:0] word_t;

    localparam word_t IDLE_C  = 3'd0;
    localparam word_t S1_A_C  = 3'd1;
    localparam word_t S1_B_C  = 3'd2;
    localparam word_t S1_C_C  = 3'd3;
    localparam word_t S2_A_C  = 3'd4;
    localparam word_t S2_B_C  = 3'd5;
    localparam word_t S2_C_C  = 3'd6;
    localparam word_t ERROR_C = 3'd7;

    // Expected sequence at default encodings, index 0 is the phase anchor.
    localparam word_t SEQ_C [SEQ_LEN_C] = '{
        S2_A_C, S2_B_C, S2_C_C, S2_A_C, S2_B_C, S2_C_C,
        S1_A_C, S1_B_C, S1_C_C, S1_A_C, S1_B_C, S1_C_C
    };

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk_i/rst_ni clock and async active-low reset, clr synchronous
// clear (wins over inc), inc count enable, count current value.
module sat_counter #(
    parameter int unsigned CNT_WIDTH_G = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr,
    input  logic                   inc,
    output logic [CNT_WIDTH_G-1:0] count
);

    // Holds at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_WIDTH_G'(1);
        end
    end

endmodule

// File: rtl/pattern_checker.sv
// Receive-side lane pattern checker. Locks onto the phase of the 12-step
// sequence, then flags and counts every mismatching word while locked.
// Ports: clk_i/rst_ni clock and async active-low reset, clear_i clears both
// counters, data_i received word; locked_o high while locked, error_o
// one-cycle pulse per locked mismatch, error_count_o / lock_loss_count_o
// saturating mismatch and lock-loss counts.
module pattern_checker
    import pattern_pkg::*;
#(
    parameter int unsigned           IO_SIZE_G    = IO_SIZE_C,
    parameter logic [IO_SIZE_G-1:0]  IDLE         = IO_SIZE_G'(IDLE_C),
    parameter logic [IO_SIZE_G-1:0]  S1_A         = IO_SIZE_G'(S1_A_C),
    parameter logic [IO_SIZE_G-1:0]  S1_B         = IO_SIZE_G'(S1_B_C),
    parameter logic [IO_SIZE_G-1:0]  S1_C         = IO_SIZE_G'(S1_C_C),
    parameter logic [IO_SIZE_G-1:0]  S2_A         = IO_SIZE_G'(S2_A_C),
    parameter logic [IO_SIZE_G-1:0]  S2_B         = IO_SIZE_G'(S2_B_C),
    parameter logic [IO_SIZE_G-1:0]  S2_C         = IO_SIZE_G'(S2_C_C),
    parameter logic [IO_SIZE_G-1:0]  ERROR        = IO_SIZE_G'(ERROR_C),
    parameter int unsigned           LOCK_COUNT_G = 12,
    parameter int unsigned           MAX_MISS_G   = 4,
    parameter int unsigned           CNT_WIDTH_G  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [IO_SIZE_G-1:0]   data_i,
    output logic                   locked_o,
    output logic                   error_o,
    output logic [CNT_WIDTH_G-1:0] error_count_o,
    output logic [CNT_WIDTH_G-1:0] lock_loss_count_o
);

    localparam int unsigned IDX_W   = $clog2(SEQ_LEN_C);
    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT_G + 1);
    localparam int unsigned MISS_W  = $clog2(MAX_MISS_G + 1);

    // Sequence rebuilt from the encoding parameters, same order as SEQ_C.
    localparam logic [IO_SIZE_G-1:0] SEQ [SEQ_LEN_C] = '{
        S2_A, S2_B, S2_C, S2_A, S2_B, S2_C,
        S1_A, S1_B, S1_C, S1_A, S1_B, S1_C
    };

    // Idle and error words must never be mistaken for the anchor.
    if ((IDLE == S2_A) || (ERROR == S2_A) || (IDLE == ERROR)) begin : g_bad_enc
        $error("pattern_checker: IDLE/ERROR encodings collide with S2_A");
    end

    chk_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d, idx_inc;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [MISS_W-1:0]    miss_q, miss_d;
    logic                 locked_q, error_q;
    logic                 hit, anchor, err_inc, loss_inc;

    assign hit     = (data_i == SEQ[idx_q]);
    assign anchor  = (data_i == S2_A);
    assign idx_inc = (idx_q == IDX_W'(SEQ_LEN_C - 1)) ? '0 : idx_q + IDX_W'(1);

    // Next-state logic; an anchor seen in SEARCH or as a SYNC mismatch
    // counts as the first match at index 0.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        match_d  = match_q;
        miss_d   = miss_q;
        err_inc  = 1'b0;
        loss_inc = 1'b0;
        unique case (state_q)
            ST_SEARCH: begin
                if (anchor) begin
                    idx_d   = IDX_W'(1);
                    match_d = MATCH_W'(1);
                    miss_d  = '0;
                    state_d = (LOCK_COUNT_G == 1) ? ST_LOCKED : ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (hit) begin
                    idx_d = idx_inc;
                    if (match_q == MATCH_W'(LOCK_COUNT_G - 1)) begin
                        state_d = ST_LOCKED;
                        miss_d  = '0;
                    end else begin
                        match_d = match_q + MATCH_W'(1);
                    end
                end else if (anchor) begin
                    idx_d   = IDX_W'(1);
                    match_d = MATCH_W'(1);
                    state_d = (LOCK_COUNT_G == 1) ? ST_LOCKED : ST_SYNC;
                end else begin
                    idx_d   = '0;
                    state_d = ST_SEARCH;
                end
            end
            ST_LOCKED: begin
                // Phase free-runs so an isolated upset cannot shift it.
                idx_d = idx_inc;
                if (hit) begin
                    miss_d = '0;
                end else begin
                    err_inc = 1'b1;
                    if (miss_q == MISS_W'(MAX_MISS_G - 1)) begin
                        miss_d   = '0;
                        idx_d    = '0;
                        loss_inc = 1'b1;
                        state_d  = ST_SEARCH;
                    end else begin
                        miss_d = miss_q + MISS_W'(1);
                    end
                end
            end
            default: begin
                idx_d   = '0;
                state_d = ST_SEARCH;
            end
        endcase
    end

    // State, phase and registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_SEARCH;
            idx_q    <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            locked_q <= (state_d == ST_LOCKED);
            error_q  <= err_inc;
        end
    end

    assign locked_o = locked_q;
    assign error_o  = error_q;

    sat_counter #(.CNT_WIDTH_G(CNT_WIDTH_G)) u_err_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (clear_i),
        .inc    (err_inc),
        .count  (error_count_o)
    );

    sat_counter #(.CNT_WIDTH_G(CNT_WIDTH_G)) u_loss_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (clear_i),
        .inc    (loss_inc),
        .count  (lock_loss_count_o)
    );

endmodule

// File: tb/tb_pattern_checker.sv
// Directed bench for pattern_checker: a 16-bit and a 4-bit counter instance
// share the stimulus; a behavioural model queues expected outputs per word.
module tb_pattern_checker;

    localparam logic [2:0] W_IDLE = 3'd0;
    localparam logic [2:0] W_S1B  = 3'd2;
    localparam logic [2:0] W_S2A  = 3'd4;
    localparam logic [2:0] W_S2B  = 3'd5;
    localparam logic [2:0] W_ERR  = 3'd7;
    localparam logic [2:0] TSEQ [12] = '{3'd4, 3'd5, 3'd6, 3'd4, 3'd5, 3'd6,
                                         3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3};
    localparam int LOCK_N = 12;
    localparam int MISS_N = 4;

    typedef struct packed {
        logic        locked;
        logic        err;
        logic [15:0] ec16;
        logic [15:0] lc16;
        logic [3:0]  ec4;
        logic [3:0]  lc4;
    } exp_t;

    logic        clk, rst_n, clear;
    logic [2:0]  data;
    logic        locked16, err16, locked4, err4;
    logic [15:0] ec16, lc16;
    logic [3:0]  ec4, lc4;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    // model state
    int m_st, m_idx, m_mc, m_miss, m_ec, m_lc;
    int p;

    pattern_checker #(.CNT_WIDTH_G(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .data_i(data),
        .locked_o(locked16), .error_o(err16),
        .error_count_o(ec16), .lock_loss_count_o(lc16)
    );

    pattern_checker #(.CNT_WIDTH_G(4)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .data_i(data),
        .locked_o(locked4), .error_o(err4),
        .error_count_o(ec4), .lock_loss_count_o(lc4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_idx = 0; m_mc = 0; m_miss = 0; m_ec = 0; m_lc = 0;
        q.delete();
    endtask

    // Drive one word, advance the model, compare after the sampling edge.
    task automatic step(input logic [2:0] d, input logic clr);
        exp_t e;
        logic hit, m_err;
        data  = d;
        clear = clr;
        m_err = 1'b0;
        hit   = (d == TSEQ[m_idx]);
        case (m_st)
            0: if (d == W_S2A) begin m_st = 1; m_idx = 1; m_mc = 1; end
            1: begin
                if (hit) begin
                    m_mc++;
                    m_idx = (m_idx + 1) % 12;
                    if (m_mc == LOCK_N) begin m_st = 2; m_miss = 0; end
                end else if (d == W_S2A) begin
                    m_idx = 1; m_mc = 1;
                end else begin
                    m_st = 0; m_idx = 0;
                end
            end
            default: begin
                m_idx = (m_idx + 1) % 12;
                if (hit) m_miss = 0;
                else begin
                    m_err = 1'b1;
                    m_miss++;
                    m_ec++;
                    if (m_miss == MISS_N) begin
                        m_st = 0; m_miss = 0; m_idx = 0; m_lc++;
                    end
                end
            end
        endcase
        if (clr) begin m_ec = 0; m_lc = 0; end
        e.locked = (m_st == 2);
        e.err    = m_err;
        e.ec16   = (m_ec > 65535) ? 16'hFFFF : 16'(m_ec);
        e.lc16   = (m_lc > 65535) ? 16'hFFFF : 16'(m_lc);
        e.ec4    = (m_ec > 15) ? 4'hF : 4'(m_ec);
        e.lc4    = (m_lc > 15) ? 4'hF : 4'(m_lc);
        q.push_back(e);
        @(posedge clk);
        #1;
        clear = 1'b0;
        if (q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk("locked16", 32'(locked16), 32'(e.locked));
            chk("error16",  32'(err16),    32'(e.err));
            chk("ecnt16",   32'(ec16),     32'(e.ec16));
            chk("lcnt16",   32'(lc16),     32'(e.lc16));
            chk("locked4",  32'(locked4),  32'(e.locked));
            chk("error4",   32'(err4),     32'(e.err));
            chk("ecnt4",    32'(ec4),      32'(e.ec4));
            chk("lcnt4",    32'(lc4),      32'(e.lc4));
        end
    endtask

    task automatic good(input int n);
        for (int i = 0; i < n; i++) begin
            step(TSEQ[p], 1'b0);
            p = (p + 1) % 12;
        end
    endtask

    task automatic bad(input logic [2:0] d, input logic clr);
        step(d, clr);
        p = (p + 1) % 12;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"}, 32'({locked16, locked4}), 32'd0);
        chk({tag, "_error"},  32'({err16, err4}),       32'd0);
        chk({tag, "_ecnt"},   32'({ec16, ec4}),         32'd0);
        chk({tag, "_lcnt"},   32'({lc16, lc4}),         32'd0);
    endtask

    initial begin
        rst_n = 1'b1; clear = 1'b0; data = W_IDLE;
        model_reset();
        p = 0;
        #2 rst_n = 1'b0;
        #2 chk_all_zero("reset");
        #18 rst_n = 1'b1;

        // clean lock
        for (int i = 0; i < 3; i++) step(W_IDLE, 1'b0);
        good(11);
        chk("lock_after_11", 32'(locked16), 32'd0);
        good(1);
        chk("lock_after_12", 32'(locked16), 32'd1);
        good(100);
        chk("clean_ecnt", 32'(ec16), 32'd0);

        // single upset: S2_B replaced by S1_B
        while (TSEQ[p] != W_S2B) good(1);
        bad(W_S1B, 1'b0);
        chk("upset_err",    32'(err16),    32'd1);
        chk("upset_ecnt",   32'(ec16),     32'd1);
        chk("upset_locked", 32'(locked16), 32'd1);
        good(1);
        chk("upset_next_err", 32'(err16), 32'd0);
        good(20);
        chk("upset_ecnt_hold", 32'(ec16), 32'd1);

        // lock loss on 4 IDLE words
        for (int i = 0; i < 4; i++) begin
            bad(W_IDLE, 1'b0);
            chk("loss_err", 32'(err16), 32'd1);
            chk("loss_locked", 32'(locked16), (i < 3) ? 32'd1 : 32'd0);
        end
        chk("loss_lcnt", 32'(lc16), 32'd1);
        chk("loss_ecnt", 32'(ec16), 32'd5);
        p = 0;
        good(11);
        chk("relock_11", 32'(locked16), 32'd0);
        good(1);
        chk("relock_12", 32'(locked16), 32'd1);

        // false anchor in SYNC
        for (int i = 0; i < 4; i++) bad(W_IDLE, 1'b0);
        chk("drop2_lcnt", 32'(lc16), 32'd2);
        step(W_S2A, 1'b0);
        step(W_S2B, 1'b0);
        step(W_S2A, 1'b0);
        p = 1;
        good(10);
        chk("false_anchor_11", 32'(locked16), 32'd0);
        good(1);
        chk("false_anchor_12", 32'(locked16), 32'd1);
        chk("false_anchor_ecnt", 32'(ec16), 32'd9);

        // saturation of the 4-bit instance
        for (int i = 0; i < 20; i++) begin
            bad(W_ERR, 1'b0);
            good(1);
        end
        chk("sat_ecnt4",  32'(ec4),      32'd15);
        chk("sat_ecnt16", 32'(ec16),     32'd29);
        chk("sat_locked", 32'(locked16), 32'd1);
        bad(W_ERR, 1'b1);
        chk("clear_ecnt16", 32'(ec16), 32'd0);
        chk("clear_ecnt4",  32'(ec4),  32'd0);
        chk("clear_lcnt",   32'(lc16), 32'd0);
        chk("clear_err",    32'(err16), 32'd1);
        good(3);

        // async reset mid-lock, between edges, with error_o high
        bad(W_ERR, 1'b0);
        chk("pre_rst_locked", 32'(locked16), 32'd1);
        chk("pre_rst_err",    32'(err16),    32'd1);
        chk("pre_rst_ecnt",   32'(ec16),     32'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        model_reset();
        p = 0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) step(W_IDLE, 1'b0);
        good(12);
        chk("post_rst_lock", 32'(locked16), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
